// File: rtl/flippy_pkg.sv
// Shared constants for the Flippy Bit game and its input front end.
package flippy_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 1;

  // Clock cycles between debounce samples.
  localparam int SAMPLE_DIV_DEFAULT     = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int STABLE_SAMPLES_DEFAULT = 4;

  localparam int NUM_SWITCHES = 8;
  localparam int NUM_BUTTONS  = 2;

  typedef enum logic [0:0] {
    BTN_START = 1'b0,
    BTN_FIRE  = 1'b1
  } btn_idx_e;

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/flippy_input_debounce_cell.sv
// Single-input debouncer: accepts a new level only after STABLE_SAMPLES
// consecutive tick samples all agree on it.
module debounce_cell #(
  parameter int   STABLE_SAMPLES = 4,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic level
);

  logic [STABLE_SAMPLES-1:0] hist;
  logic [STABLE_SAMPLES-1:0] hist_next;
  logic                      qualify;

  // The sample taken this edge counts toward the run, so test the shifted value.
  always_comb begin
    hist_next = {hist[STABLE_SAMPLES-2:0], din};
    qualify   = (hist_next == {STABLE_SAMPLES{~level}});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist  <= {STABLE_SAMPLES{RESET_LEVEL}};
      level <= RESET_LEVEL;
    end else if (tick) begin
      hist <= hist_next;
      if (qualify) begin
        level <= ~level;
      end
    end
  end

endmodule

// File: rtl/flippy_input.sv
// Board-pin front end: synchronizes and debounces switches and buttons and
// produces the user_bits word plus single-cycle start/fire/change pulses.
module flippy_input
  import flippy_pkg::*;
#(
  parameter int SAMPLE_DIV     = SAMPLE_DIV_DEFAULT,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SWITCHES-1:0] sw_raw,
  input  logic                    btn_start_n,
  input  logic                    btn_fire_n,
  output logic [NUM_SWITCHES-1:0] user_bits,
  output logic                    start_pulse,
  output logic                    fire_pulse,
  output logic                    bits_changed
);

  localparam int                CNT_W    = cnt_width(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [NUM_SWITCHES-1:0] sw_p0;
  logic [NUM_SWITCHES-1:0] sw_p1;
  logic [NUM_BUTTONS-1:0]  btn_p0;
  logic [NUM_BUTTONS-1:0]  btn_p1;

  logic [CNT_W-1:0]        count;
  logic                    tick;

  logic [NUM_BUTTONS-1:0]  btn_level;
  logic [NUM_BUTTONS-1:0]  pressed;
  logic [NUM_BUTTONS-1:0]  pressed_prev;
  logic [NUM_SWITCHES-1:0] bits_prev;

  // Stage p0/p1: two-flop synchronizers; buttons idle high (released).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= '1;
      btn_p1 <= '1;
    end else begin
      sw_p0  <= sw_raw;
      sw_p1  <= sw_p0;
      btn_p0 <= {btn_fire_n, btn_start_n};
      btn_p1 <= btn_p0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CNT_LAST);

  // Stage debounce: one cell per synchronized input.
  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .RESET_LEVEL    (1'b0)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .din   (sw_p1[i]),
      .level (user_bits[i])
    );
  end

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .RESET_LEVEL    (1'b1)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .din   (btn_p1[b]),
      .level (btn_level[b])
    );
  end

  assign pressed = ~btn_level;

  // Stage edge: compare debounced levels against their value one cycle ago.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pressed_prev <= '0;
      bits_prev    <= '0;
    end else begin
      pressed_prev <= pressed;
      bits_prev    <= user_bits;
    end
  end

  assign start_pulse  = pressed[BTN_START] & ~pressed_prev[BTN_START];
  assign fire_pulse   = pressed[BTN_FIRE]  & ~pressed_prev[BTN_FIRE];
  assign bits_changed = |(user_bits ^ bits_prev);

endmodule

// File: tb/tb_flippy_input.sv
// Scoreboard bench for flippy_input with SAMPLE_DIV=4, STABLE_SAMPLES=3.
module tb_flippy_input;

  localparam int DIV     = 4;
  localparam int NS      = 3;
  localparam int LAT_MIN = 2 + (NS - 1) * DIV + 1;
  localparam int LAT_MAX = 2 + NS * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_raw = 8'h00;
  logic       btn_start_n = 1'b1;
  logic       btn_fire_n = 1'b1;
  logic [7:0] user_bits;
  logic       start_pulse;
  logic       fire_pulse;
  logic       bits_changed;

  typedef struct {
    logic [7:0] bits;
    logic       st;
    logic       fi;
    logic       ch;
    int         cyc;
  } evt_t;

  typedef struct {
    logic [7:0] bits;
    logic       st;
    logic       fi;
    logic       ch;
    int         lo;
    int         hi;
  } exp_t;

  evt_t obs_q[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  flippy_input #(
    .SAMPLE_DIV     (DIV),
    .STABLE_SAMPLES (NS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .btn_start_n  (btn_start_n),
    .btn_fire_n   (btn_fire_n),
    .user_bits    (user_bits),
    .start_pulse  (start_pulse),
    .fire_pulse   (fire_pulse),
    .bits_changed (bits_changed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (start_pulse || fire_pulse || bits_changed)
      obs_q.push_back('{user_bits, start_pulse, fire_pulse, bits_changed, cyc});
  end

  task automatic apply_reset();
    sw_raw      = 8'h00;
    btn_start_n = 1'b1;
    btn_fire_n  = 1'b1;
    reset       = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    evt_t o;
    exp_t e;
    reset       = 1'b1;
    sw_raw      = 8'h5A;
    btn_start_n = 1'b0;
    btn_fire_n  = 1'b0;
    repeat (20) @(negedge clock);
    total++;
    if (user_bits !== 8'h00) begin
      bad++;
      $display("FAIL reset_bits: got %h want 00", user_bits);
    end
    total++;
    if ({start_pulse, fire_pulse, bits_changed} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 000", {start_pulse, fire_pulse, bits_changed});
    end
    apply_reset();
    repeat (30) @(negedge clock);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL reset_idle_events: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
    end
    total++;
    if (user_bits !== 8'h00) begin
      bad++;
      $display("FAIL reset_idle_bits: got %h want 00", user_bits);
    end
  endtask

  task automatic test_switch_change();
    evt_t o;
    exp_t e;
    int   t0;
    apply_reset();
    repeat (5) @(negedge clock);
    t0 = cyc;
    sw_raw = 8'hA5;
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b1, t0 + LAT_MIN, t0 + LAT_MAX});
    repeat (30) @(negedge clock);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL switch_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if ({o.bits, o.st, o.fi, o.ch} !== {e.bits, e.st, e.fi, e.ch} || o.cyc < e.lo || o.cyc > e.hi) begin
        bad++;
        $display("FAIL switch_evt: got bits=%h st=%b fi=%b ch=%b cyc=%0d want bits=%h st=%b fi=%b ch=%b cyc in [%0d,%0d]",
                 o.bits, o.st, o.fi, o.ch, o.cyc, e.bits, e.st, e.fi, e.ch, e.lo, e.hi);
      end
    end
    total++;
    if (user_bits !== 8'hA5) begin
      bad++;
      $display("FAIL switch_final: got %h want a5", user_bits);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    repeat (3) @(negedge clock);
    sw_raw[3] = 1'b1;
    repeat (6) @(negedge clock);
    sw_raw[3] = 1'b0;
    repeat (40) @(negedge clock);
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_events: got %0d want 0", obs_q.size());
    end
    total++;
    if (user_bits !== 8'h00) begin
      bad++;
      $display("FAIL glitch_bits: got %h want 00", user_bits);
    end
  endtask

  task automatic test_held_button();
    evt_t o;
    exp_t e;
    int   t0;
    apply_reset();
    repeat (2) @(negedge clock);
    t0 = cyc;
    btn_start_n = 1'b0;
    exp_q.push_back('{8'h00, 1'b1, 1'b0, 1'b0, t0 + LAT_MIN, t0 + LAT_MAX});
    repeat (200) @(negedge clock);
    btn_start_n = 1'b1;
    repeat (40) @(negedge clock);
    t0 = cyc;
    btn_start_n = 1'b0;
    exp_q.push_back('{8'h00, 1'b1, 1'b0, 1'b0, t0 + LAT_MIN, t0 + LAT_MAX});
    repeat (40) @(negedge clock);
    btn_start_n = 1'b1;
    repeat (30) @(negedge clock);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL held_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if ({o.bits, o.st, o.fi, o.ch} !== {e.bits, e.st, e.fi, e.ch} || o.cyc < e.lo || o.cyc > e.hi) begin
        bad++;
        $display("FAIL held_evt: got bits=%h st=%b fi=%b ch=%b cyc=%0d want bits=%h st=%b fi=%b ch=%b cyc in [%0d,%0d]",
                 o.bits, o.st, o.fi, o.ch, o.cyc, e.bits, e.st, e.fi, e.ch, e.lo, e.hi);
      end
    end
  endtask

  task automatic test_simultaneous();
    evt_t o;
    exp_t e;
    int   t0;
    apply_reset();
    repeat (1) @(negedge clock);
    t0 = cyc;
    btn_start_n = 1'b0;
    btn_fire_n  = 1'b0;
    exp_q.push_back('{8'h00, 1'b1, 1'b1, 1'b0, t0 + LAT_MIN, t0 + LAT_MAX});
    repeat (40) @(negedge clock);
    btn_start_n = 1'b1;
    btn_fire_n  = 1'b1;
    repeat (30) @(negedge clock);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL simul_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if ({o.bits, o.st, o.fi, o.ch} !== {e.bits, e.st, e.fi, e.ch} || o.cyc < e.lo || o.cyc > e.hi) begin
        bad++;
        $display("FAIL simul_evt: got bits=%h st=%b fi=%b ch=%b cyc=%0d want bits=%h st=%b fi=%b ch=%b cyc in [%0d,%0d]",
                 o.bits, o.st, o.fi, o.ch, o.cyc, e.bits, e.st, e.fi, e.ch, e.lo, e.hi);
      end
    end
  endtask

  task automatic test_reset_midqual();
    evt_t o;
    exp_t e;
    int   t_rel;
    apply_reset();
    @(negedge clock);
    sw_raw = 8'hFF;
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (user_bits !== 8'h00) begin
      bad++;
      $display("FAIL midq_reset_bits: got %h want 00", user_bits);
    end
    total++;
    if (bits_changed !== 1'b0) begin
      bad++;
      $display("FAIL midq_reset_changed: got %b want 0", bits_changed);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    obs_q.delete();
    exp_q.delete();
    reset = 1'b0;
    t_rel = cyc;
    exp_q.push_back('{8'hFF, 1'b0, 1'b0, 1'b1, t_rel + NS * DIV, t_rel + NS * DIV});
    repeat (30) @(negedge clock);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midq_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if ({o.bits, o.st, o.fi, o.ch} !== {e.bits, e.st, e.fi, e.ch} || o.cyc < e.lo || o.cyc > e.hi) begin
        bad++;
        $display("FAIL midq_evt: got bits=%h st=%b fi=%b ch=%b cyc=%0d want bits=%h st=%b fi=%b ch=%b cyc in [%0d,%0d]",
                 o.bits, o.st, o.fi, o.ch, o.cyc, e.bits, e.st, e.fi, e.ch, e.lo, e.hi);
      end
    end
    total++;
    if (user_bits !== 8'hFF) begin
      bad++;
      $display("FAIL midq_final: got %h want ff", user_bits);
    end
  endtask

  task automatic test_bounce();
    evt_t o;
    exp_t e;
    int   t_hold;
    apply_reset();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      btn_fire_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) @(negedge clock);
    end
    t_hold = cyc;
    btn_fire_n = 1'b0;
    // The last bounce samples may join the run, but the final one must come from the hold.
    exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b0, t_hold + 3, t_hold + LAT_MAX});
    repeat (40) @(negedge clock);
    btn_fire_n = 1'b1;
    repeat (30) @(negedge clock);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bounce_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if ({o.bits, o.st, o.fi, o.ch} !== {e.bits, e.st, e.fi, e.ch} || o.cyc < e.lo || o.cyc > e.hi) begin
        bad++;
        $display("FAIL bounce_evt: got bits=%h st=%b fi=%b ch=%b cyc=%0d want bits=%h st=%b fi=%b ch=%b cyc in [%0d,%0d]",
                 o.bits, o.st, o.fi, o.ch, o.cyc, e.bits, e.st, e.fi, e.ch, e.lo, e.hi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch_change();
    test_glitch();
    test_held_button();
    test_simultaneous();
    test_reset_midqual();
    test_bounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
